// File: rtl/mux2_pkg.sv
// rtl/mux2_pkg.sv - shared source indices and reset pointer for the 2:1 stream arbiter
package mux2_pkg;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

  // Pointer resets to d1 so the first tie goes to d0.
  localparam logic LAST_GRANT_RST = SRC_D1;

  function automatic logic other_src(input logic src);
    return (src == SRC_D0) ? SRC_D1 : SRC_D0;
  endfunction

endpackage

// File: rtl/mux2_rr_grant.sv
// rtl/mux2_rr_grant.sv - combinational two-way grant; MUX2_ARB_FIXED_PRIO_EN selects fixed d0 priority
module mux2_rr_grant
  import mux2_pkg::*;
(
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  input  logic accept,
  output logic g0,
  output logic g1
);

`ifdef MUX2_ARB_FIXED_PRIO_EN
  // Pointer is still tracked by the top but plays no part in the tie-break.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (accept) begin
      if (v0 && v1) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
        g0 = 1'b1;
`else
        g0 = (other_src(last_grant) == SRC_D0);
        g1 = (other_src(last_grant) == SRC_D1);
`endif
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin two-source stream arbiter with registered output (MUX2_ARB_FIXED_PRIO_EN: fixed priority)
module mux2_rr_arbiter
  import mux2_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d0,
  input  logic             d0_valid,
  output logic             d0_ready,
  input  logic [WIDTH-1:0] d1,
  input  logic             d1_valid,
  output logic             d1_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic accept;
  logic g0;
  logic g1;
  logic last_grant;
  logic xfer0;
  logic xfer1;

  // Register can take a word when empty or when its current word leaves this cycle.
  assign accept = !out_valid || out_ready;

  mux2_rr_grant u_grant (
    .v0         (d0_valid),
    .v1         (d1_valid),
    .last_grant (last_grant),
    .accept     (accept),
    .g0         (g0),
    .g1         (g1)
  );

  assign d0_ready = g0;
  assign d1_ready = g1;
  assign xfer0    = d0_valid && g0;
  assign xfer1    = d1_valid && g1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out        <= '0;
      out_sel    <= SRC_D0;
      out_valid  <= 1'b0;
      last_grant <= LAST_GRANT_RST;
    end else if (xfer0 || xfer1) begin
      out        <= xfer1 ? d1 : d0;
      out_sel    <= xfer1 ? SRC_D1 : SRC_D0;
      out_valid  <= 1'b1;
      last_grant <= xfer1 ? SRC_D1 : SRC_D0;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - scoreboard bench for mux2_rr_arbiter (MUX2_ARB_FIXED_PRIO_EN aware)
module tb_mux2_rr_arbiter;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] d0 = '0;
  logic         d0_valid = 1'b0;
  logic         d0_ready;
  logic [W-1:0] d1 = '0;
  logic         d1_valid = 1'b0;
  logic         d1_ready;
  logic [W-1:0] out;
  logic         out_sel;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [W:0] sb[$];
  logic       m_lg = 1'b1;
  logic       m_ov = 1'b0;

`ifdef MUX2_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  mux2_rr_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .d0        (d0),
    .d0_valid  (d0_valid),
    .d0_ready  (d0_ready),
    .d1        (d1),
    .d1_valid  (d1_valid),
    .d1_ready  (d1_ready),
    .out       (out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model and scoreboard, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic acc, e0, e1;
    logic [W:0] exp_w;
    if (!reset_n) begin
      sb.delete();
      m_lg = 1'b1;
      m_ov = 1'b0;
    end else begin
      acc = !m_ov || out_ready;
      e0 = 1'b0;
      e1 = 1'b0;
      if (acc) begin
        if (d0_valid && d1_valid) begin
          e0 = FIXED ? 1'b1 : (m_lg == 1'b1);
          e1 = FIXED ? 1'b0 : (m_lg == 1'b0);
        end else begin
          e0 = d0_valid;
          e1 = d1_valid;
        end
      end
      checks++;
      if ({d0_ready, d1_ready} !== {e0, e1}) begin
        failures++;
        $display("FAIL readies got=%b%b exp=%b%b t=%0t", d0_ready, d1_ready, e0, e1, $time);
      end
      checks++;
      if (out_valid !== m_ov) begin
        failures++;
        $display("FAIL out_valid_model got=%b exp=%b t=%0t", out_valid, m_ov, $time);
      end
      if (m_ov && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow got=%b%b exp=empty t=%0t", out_sel, out, $time);
        end else begin
          exp_w = sb.pop_front();
          if ({out_sel, out} !== exp_w) begin
            failures++;
            $display("FAIL sb_word got=%b exp=%b t=%0t", {out_sel, out}, exp_w, $time);
          end
        end
      end
      if (e0) begin
        sb.push_back({1'b0, d0});
        m_lg = 1'b0;
        m_ov = 1'b1;
      end else if (e1) begin
        sb.push_back({1'b1, d1});
        m_lg = 1'b1;
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    d0_valid = 1'b0;
    d1_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    checks++;
    if ({out, out_sel, out_valid} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=0000", {out, out_sel, out_valid});
    end
    checks++;
    if ({d0_ready, d1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_readies got=%b%b exp=00", d0_ready, d1_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    d0 = 2'b10;
    d0_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (d0_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got=%b exp=1", d0_ready);
    end
    tick();
    d0_valid = 1'b0;
    checks++;
    if ({out, out_sel, out_valid} !== {2'b10, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_out got=%b exp=1001", {out, out_sel, out_valid});
    end
    tick();
  endtask

  task automatic test_alternate();
    logic r0, r1;
    do_reset();
    d0 = 2'b00;
    d1 = 2'b11;
    d0_valid = 1'b1;
    d1_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      r0 = d0_ready;
      r1 = d1_ready;
      tick();
      checks++;
      if ({out_sel, out_valid} !== {FIXED ? 1'b0 : 1'(i % 2), 1'b1}) begin
        failures++;
        $display("FAIL alt_sel[%0d] got=%b%b exp=%b1", i, out_sel, out_valid,
                 FIXED ? 1'b0 : 1'(i % 2));
      end
      if (r0) d0 = W'($urandom);
      if (r1) d1 = W'($urandom);
    end
    d0_valid = 1'b0;
    d1_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stall();
    logic [W-1:0] o;
    logic s, r0, r1;
    do_reset();
    d0 = 2'b01;
    d1 = 2'b10;
    d0_valid = 1'b1;
    d1_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    d0 = 2'b11;
    o = out;
    s = out_sel;
    checks++;
    if ({o, s} !== {2'b01, 1'b0}) begin
      failures++;
      $display("FAIL stall_fill got=%b exp=010", {o, s});
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({d0_ready, d1_ready} !== 2'b00) begin
        failures++;
        $display("FAIL stall_readies[%0d] got=%b%b exp=00", i, d0_ready, d1_ready);
      end
      tick();
      checks++;
      if ({out, out_sel, out_valid} !== {o, s, 1'b1}) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%b exp=%b", i, {out, out_sel, out_valid}, {o, s, 1'b1});
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r0 = d0_ready;
      r1 = d1_ready;
      tick();
      checks++;
      if (out_sel !== (FIXED ? 1'b0 : 1'(~i & 1))) begin
        failures++;
        $display("FAIL stall_release[%0d] got=%b exp=%b", i, out_sel, FIXED ? 1'b0 : 1'(~i & 1));
      end
      if (r0) d0 = d0 + 2'd1;
      if (r1) d1 = d1 + 2'd1;
    end
    d0_valid = 1'b0;
    d1_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_d1_toggle();
    logic v;
    logic [W-1:0] dat;
    do_reset();
    out_ready = 1'b1;
    d0_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0);
      dat = W'(i / 2 + 1);
      d1 = dat;
      d1_valid = v;
      tick();
      checks++;
      if (out_valid !== v || (v && {out, out_sel} !== {dat, 1'b1})) begin
        failures++;
        $display("FAIL d1_toggle[%0d] got=%b exp=%b", i, {out, out_sel, out_valid}, {dat, 1'b1, v});
      end
    end
    d1_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic r0, r1;
    do_reset();
    d0 = 2'b01;
    d1 = 2'b10;
    d0_valid = 1'b1;
    d1_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      r0 = d0_ready;
      r1 = d1_ready;
      tick();
      if (r0) d0 = d0 + 2'd1;
      if (r1) d1 = d1 + 2'd1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out, out_sel} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=0000", {out_valid, out, out_sel});
    end
    d0_valid = 1'b0;
    d1_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    d0_valid = 1'b1;
    d1_valid = 1'b1;
    tick();
    checks++;
    if ({out_sel, out_valid} !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid_first_tie got=%b%b exp=01", out_sel, out_valid);
    end
    d0_valid = 1'b0;
    d1_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_tie_policy();
    logic r0, r1;
    do_reset();
    d0 = 2'b11;
    d1 = 2'b00;
    d0_valid = 1'b1;
    d1_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r0 = d0_ready;
      r1 = d1_ready;
      checks++;
      if (r1 !== (FIXED ? 1'b0 : 1'(i % 2))) begin
        failures++;
        $display("FAIL tie_d1_ready[%0d] got=%b exp=%b", i, r1, FIXED ? 1'b0 : 1'(i % 2));
      end
      tick();
      checks++;
      if (out_sel !== (FIXED ? 1'b0 : 1'(i % 2))) begin
        failures++;
        $display("FAIL tie_sel[%0d] got=%b exp=%b", i, out_sel, FIXED ? 1'b0 : 1'(i % 2));
      end
      if (r0) d0 = d0 - 2'd1;
      if (r1) d1 = d1 + 2'd1;
    end
    d0_valid = 1'b0;
    d1_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_d1_toggle();
    test_reset_mid();
    test_tie_policy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
